// File: rtl/usb_tx_line.sv
// Full-speed USB transmit line encoder: paces serializer bits at the line rate,
// inserts stuff bits, NRZI-encodes, appends SE0/SE0/J and drives the pad signals.
module usb_tx_line #(
  parameter int CLK_DIV = 4  // clock cycles per line bit, legal 3..16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ll_start,
  input  logic ll_bit,
  input  logic ll_last,
  output logic ll_ack,
  output logic phy_tx_dp,
  output logic phy_tx_dn,
  output logic phy_tx_en
);

  localparam int               CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       STUFF_RUN = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    EOP0,
    EOP1,
    EOPJ
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_ones, w_ones_nxt;
  logic             r_last_seen, w_last_seen_nxt;
  logic             r_lvl, w_lvl_nxt;
  logic             r_dp, r_dn, r_en;
  logic             w_dp_nxt, w_dn_nxt, w_en_nxt;
  logic             w_slot_start;

  assign w_slot_start = (r_cnt == '0);

  // Decoded purely from registered state so upstream sees a clean one-cycle pulse.
  assign ll_ack = (r_state == DATA) && w_slot_start && (r_ones != STUFF_RUN) && !r_last_seen;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ones_nxt      = r_ones;
    w_last_seen_nxt = r_last_seen;
    w_lvl_nxt       = r_lvl;

    if (r_state != IDLE) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (ll_start) begin
          w_state_nxt     = DATA;
          w_cnt_nxt       = '0;
          w_ones_nxt      = '0;
          w_last_seen_nxt = 1'b0;
        end
      end
      DATA: begin
        if (w_slot_start) begin
          if (r_ones == STUFF_RUN) begin
            w_lvl_nxt  = ~r_lvl;
            w_ones_nxt = '0;
          end else if (r_last_seen) begin
            w_state_nxt = EOP0;
          end else begin
            w_lvl_nxt       = ll_bit ? r_lvl : ~r_lvl;
            w_ones_nxt      = ll_bit ? r_ones + 3'd1 : 3'd0;
            w_last_seen_nxt = ll_last;
          end
        end
      end
      EOP0: if (w_slot_start) w_state_nxt = EOP1;
      EOP1: if (w_slot_start) w_state_nxt = EOPJ;
      EOPJ: begin
        if (w_slot_start) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_lvl_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Pads follow the slot being entered; the IDLE->DATA edge only arms the first slot.
    w_en_nxt = (r_state != IDLE) && (w_state_nxt != IDLE);
    case (w_state_nxt)
      DATA: begin
        w_dp_nxt = w_lvl_nxt;
        w_dn_nxt = ~w_lvl_nxt;
      end
      EOP0, EOP1: begin
        w_dp_nxt = 1'b0;
        w_dn_nxt = 1'b0;
      end
      default: begin
        w_dp_nxt = 1'b1;
        w_dn_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ones      <= '0;
      r_last_seen <= 1'b0;
      r_lvl       <= 1'b1;
      r_dp        <= 1'b1;
      r_dn        <= 1'b0;
      r_en        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ones      <= w_ones_nxt;
      r_last_seen <= w_last_seen_nxt;
      r_lvl       <= w_lvl_nxt;
      r_dp        <= w_dp_nxt;
      r_dn        <= w_dn_nxt;
      r_en        <= w_en_nxt;
    end
  end

  assign phy_tx_dp = r_dp;
  assign phy_tx_dn = r_dn;
  assign phy_tx_en = r_en;

endmodule
